// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: opcodes, jump controls,
// fetch FSM states and the IF/ID bundle.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [1:0] JC_J   = 2'd0;
  localparam logic [1:0] JC_JAL = 2'd1;
  localparam logic [1:0] JC_JR  = 2'd2;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    FULL,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc4;
  } if_id_t;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect decision and target for a resolving
// branch/jump, plus JR alignment check.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic        res_valid_i,
  input  logic        branch_i,
  input  logic        branch_eq_i,
  input  logic        jump_i,
  input  logic [1:0]  jump_ctrl_i,
  input  logic        zero_i,
  input  logic [31:0] res_pc4_i,
  input  logic [15:0] res_imm_i,
  input  logic [25:0] res_jidx_i,
  input  logic [31:0] res_rs_i,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misalign
);

  logic take_br;
  logic is_jr;
  logic is_jabs;

  assign take_br = branch_i &&
    (branch_eq_i ? zero_i : !zero_i);
  assign redirect = res_valid_i &&
    (jump_i || take_br);
  assign is_jr   = jump_i && (jump_ctrl_i == JC_JR);
  assign is_jabs = jump_i && !is_jr;
  assign misalign = res_valid_i && is_jr &&
    (res_rs_i[1:0] != 2'b00);

  // JAL and the unused encoding share the J target
  always_comb begin
    target = res_pc4_i +
      {{14{res_imm_i[15]}}, res_imm_i, 2'b00};
    unique case (1'b1)
      is_jr:   target = {res_rs_i[31:2], 2'b00};
      is_jabs: target = {res_pc4_i[31:28],
                         res_jidx_i, 2'b00};
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/gnt/rvalid handshake,
// one-entry buffer to decode, redirect flush.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_n,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_pc4_o,
  input  logic               stall_i,
  input  logic               res_valid_i,
  input  logic               branch_i,
  input  logic               branch_eq_i,
  input  logic               jump_i,
  input  logic [1:0]         jump_ctrl_i,
  input  logic               zero_i,
  input  logic [31:0]        res_pc4_i,
  input  logic [15:0]        res_imm_i,
  input  logic [25:0]        res_jidx_i,
  input  logic [31:0]        res_rs_i,
  output logic               misalign_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       buf_q, buf_d;
  logic         valid_q, valid_d;
  logic         mis_q;
  logic         run_q;
  logic         redirect;
  logic [31:0]  target;
  logic         misalign;
  logic         req_fire;

  next_pc_calc u_npc (
    .res_valid_i (res_valid_i),
    .branch_i    (branch_i),
    .branch_eq_i (branch_eq_i),
    .jump_i      (jump_i),
    .jump_ctrl_i (jump_ctrl_i),
    .zero_i      (zero_i),
    .res_pc4_i   (res_pc4_i),
    .res_imm_i   (res_imm_i),
    .res_jidx_i  (res_jidx_i),
    .res_rs_i    (res_rs_i),
    .redirect    (redirect),
    .target      (target),
    .misalign    (misalign)
  );

  // run_q keeps req low until the first edge after reset
  assign imem_req_o  = run_q && (state_q == FETCH);
  assign imem_addr_o = pc_q;
  assign req_fire    = imem_req_o && imem_gnt_i;
  assign if_valid_o  = valid_q;
  assign if_instr_o  = buf_q.instr;
  assign if_pc_o     = buf_q.pc;
  assign if_pc4_o    = buf_q.pc4;
  assign misalign_o  = mis_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      mis_q   <= misalign;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    unique case (state_q)
      FETCH: if (req_fire) state_d = WAIT;
      WAIT: if (imem_rvalid_i) begin
        buf_d.instr = imem_rdata_i;
        buf_d.pc    = pc_q;
        buf_d.pc4   = pc_q + 32'd4;
        valid_d     = 1'b1;
        pc_d        = pc_q + 32'd4;
        state_d     = FULL;
      end
      FULL: if (!stall_i) begin
        valid_d = 1'b0;
        state_d = FETCH;
      end
      DROP: if (imem_rvalid_i) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    // a redirect discards whatever is in flight
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
      buf_d   = buf_q;
      unique case (state_q)
        FETCH: state_d = req_fire ? DROP : FETCH;
        WAIT:  state_d = imem_rvalid_i ? FETCH : DROP;
        FULL:  state_d = FETCH;
        DROP:  state_d = imem_rvalid_i ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch
// addresses and decode handoffs are queued and popped.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        stall;
  logic        res_valid;
  logic        branch;
  logic        branch_eq;
  logic        jump;
  logic [1:0]  jump_ctrl;
  logic        zero;
  logic [31:0] res_pc4;
  logic [15:0] res_imm;
  logic [25:0] res_jidx;
  logic [31:0] res_rs;
  logic        misalign;
  logic        gnt_en;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int t_req   = 0;
  int t_val   = 0;

  logic [31:0] exp_req[$];
  logic [95:0] exp_out[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i         (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .if_valid_o    (if_valid),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .if_pc4_o      (if_pc4),
    .stall_i       (stall),
    .res_valid_i   (res_valid),
    .branch_i      (branch),
    .branch_eq_i   (branch_eq),
    .jump_i        (jump),
    .jump_ctrl_i   (jump_ctrl),
    .zero_i        (zero),
    .res_pc4_i     (res_pc4),
    .res_imm_i     (res_imm),
    .res_jidx_i    (res_jidx),
    .res_rs_i      (res_rs),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    return 32'h2008_0005 + (a - 32'h100);
  endfunction

  // memory: grant when enabled, answer one cycle later
  assign imem_gnt = imem_req & gnt_en;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= imem_req && imem_gnt;
      imem_rdata  <= mem_word(imem_addr);
    end
  end

  task automatic check(input string name,
                       input logic [95:0] act,
                       input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // monitor samples mid-cycle, ahead of the next edge
  always @(negedge clk) begin
    #2;
    if (rst_n && imem_req && imem_gnt) begin
      if (exp_req.size() == 0) begin
        timeout("req_unexpected");
      end else begin
        check("req_addr", imem_addr,
              exp_req.pop_front());
      end
    end
    if (rst_n && if_valid && !stall) begin
      if (exp_out.size() == 0) begin
        timeout("out_unexpected");
      end else begin
        check("if_out", {if_instr, if_pc, if_pc4},
              exp_out.pop_front());
      end
    end
  end

  task automatic expect_fetch(input logic [31:0] a);
    exp_req.push_back(a);
    exp_out.push_back({mem_word(a), a, a + 32'd4});
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) timeout("wait_req");
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!if_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!if_valid) timeout("wait_valid");
    t_val = cyc;
  endtask

  task automatic grant_one();
    gnt_en = 1'b1;
    wait_req();
    t_req = cyc;
    @(negedge clk);
    gnt_en = 1'b0;
  endtask

  task automatic resolve(input logic br,
                         input logic beq,
                         input logic jmp,
                         input logic [1:0] jc,
                         input logic z,
                         input logic [31:0] pc4,
                         input logic [15:0] imm,
                         input logic [25:0] jidx,
                         input logic [31:0] rs);
    res_valid = 1'b1;
    branch    = br;
    branch_eq = beq;
    jump      = jmp;
    jump_ctrl = jc;
    zero      = z;
    res_pc4   = pc4;
    res_imm   = imm;
    res_jidx  = jidx;
    res_rs    = rs;
    @(negedge clk);
    res_valid = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    gnt_en = 1'b1;
    stall = 1'b0;
    res_valid = 1'b0;
    branch = 1'b0;
    branch_eq = 1'b0;
    jump = 1'b0;
    jump_ctrl = 2'd0;
    zero = 1'b0;
    res_pc4 = '0;
    res_imm = '0;
    res_jidx = '0;
    res_rs = '0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_buf", {if_instr, if_pc, if_pc4}, 0);
    check("rst_misalign", misalign, 0);
    check("rst_addr", imem_addr, 32'h100);

    // first fetch and its latency
    rst_n = 1'b1;
    expect_fetch(32'h100);
    grant_one();
    wait_valid();
    check("latency", t_val - t_req, 2);

    // stalled buffer holds, no request issued
    expect_fetch(32'h104);
    grant_one();
    stall = 1'b1;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_pc", if_pc, 32'h104);
      check("stall_instr", if_instr, mem_word(32'h104));
      check("stall_req", imem_req, 0);
      @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    check("post_stall_req", imem_req, 1);
    check("post_stall_addr", imem_addr, 32'h108);

    // BEQ taken from FETCH
    resolve(1, 1, 0, 2'd0, 1, 32'h200, 16'hFFFE, 0, 0);
    check("beq_taken", imem_addr, 32'h1F8);
    expect_fetch(32'h1F8);
    grant_one();
    wait_valid();
    wait_req();
    resolve(1, 1, 0, 2'd0, 0, 32'h200, 16'hFFFE, 0, 0);
    check("beq_not_taken", imem_addr, 32'h1FC);

    // J while WAIT sees its response: drop it
    exp_req.push_back(32'h1FC);
    grant_one();
    resolve(0, 0, 1, 2'd0, 0, 32'h1000_0010, 0,
            26'h40, 0);
    check("j_wait_valid", if_valid, 0);
    check("j_wait_addr", imem_addr, 32'h1000_0100);
    check("j_wait_req", imem_req, 1);
    @(negedge clk);
    check("j_wait_valid2", if_valid, 0);
    expect_fetch(32'h1000_0100);
    grant_one();
    wait_valid();
    wait_req();

    // J in the grant cycle: goes through DROP
    exp_req.push_back(32'h1000_0104);
    gnt_en = 1'b1;
    resolve(0, 0, 1, 2'd1, 0, 32'h1000_0108, 0,
            26'h80, 0);
    gnt_en = 1'b0;
    check("drop_valid", if_valid, 0);
    check("drop_req", imem_req, 0);
    @(negedge clk);
    check("drop_valid2", if_valid, 0);
    check("drop_req2", imem_req, 1);
    check("drop_addr", imem_addr, 32'h1000_0200);

    // misaligned JR while stalled in FULL
    exp_req.push_back(32'h1000_0200);
    grant_one();
    stall = 1'b1;
    wait_valid();
    check("jr_pre_pc", if_pc, 32'h1000_0200);
    resolve(0, 0, 1, 2'd2, 0, 0, 0, 0, 32'h0000_0303);
    check("jr_flush", if_valid, 0);
    check("jr_misalign", misalign, 1);
    check("jr_addr", imem_addr, 32'h300);
    check("jr_req", imem_req, 1);
    stall = 1'b0;
    @(negedge clk);
    check("jr_misalign_end", misalign, 0);

    // PC wrap-around
    resolve(0, 0, 1, 2'd2, 0, 0, 0, 0, 32'hFFFF_FFFC);
    check("wrap_target", imem_addr, 32'hFFFF_FFFC);
    check("wrap_misalign", misalign, 0);
    expect_fetch(32'hFFFF_FFFC);
    grant_one();
    wait_valid();
    wait_req();
    check("wrap_addr", imem_addr, 32'h0);

    // asynchronous reset while WAIT
    exp_req.push_back(32'h0);
    grant_one();
    #1 rst_n = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_valid", if_valid, 0);
    check("arst_buf", {if_instr, if_pc, if_pc4}, 0);
    check("arst_misalign", misalign, 0);
    check("arst_addr", imem_addr, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    expect_fetch(32'h100);
    grant_one();
    wait_valid();
    check("latency2", t_val - t_req, 2);
    repeat (3) @(negedge clk);
    check("req_queue_empty", exp_req.size(), 0);
    check("out_queue_empty", exp_out.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end stage that sits directly upstream of the instruction decoder.
- Holds the PC and fetches 32-bit instructions over a request/grant/response instruction-memory interface.
- Buffers one fetched instruction and presents it, with its PC, to decode (opcode = instr[31:26]).
- Resolves branch/jump redirects from the decoder's control outputs (Branch, Branch_eq, Jump, Jump_Ctrl) plus the ALU zero flag, flushing stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clk_i  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req_o  output  1  fetch request; held until imem_gnt_i.
imem_addr_o  output  32  word-aligned fetch address (= PC).
imem_gnt_i  input  1  request accepted this cycle.
imem_rvalid_i  input  1  response valid; exactly one response per grant, at least 1 cycle after grant.
imem_rdata_i  input  32  instruction word.
if_valid_o  output  1  if_instr_o/if_pc_o valid for decode.
if_instr_o  output  32  buffered instruction.
if_pc_o  output  32  address of if_instr_o.
if_pc4_o  output  32  if_pc_o + 4.
stall_i  input  1  decode cannot accept; hold the buffer.
res_valid_i  input  1  qualifies the resolve inputs below for one cycle.
branch_i, branch_eq_i, jump_i  input  1 each  decoder controls of the resolving instruction.
jump_ctrl_i  input  2  0 = J, 1 = JAL, 2 = JR, 3 = treated as J.
zero_i  input  1  ALU zero flag of the resolving instruction.
res_pc4_i  input  32  PC+4 of the resolving instruction.
res_imm_i  input  16  branch offset.
res_jidx_i  input  26  jump index.
res_rs_i  input  32  rs value for JR.
misalign_o  output  1  one-cycle pulse when a JR target has bits[1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, state=FETCH, imem_req_o=0, if_valid_o=0, if_instr_o=0, if_pc_o=0, if_pc4_o=0, misalign_o=0. Responses still pending at reset are not tracked; the memory is reset by the same rst_n.
- imem_req_o is 1 in FETCH only, and is asserted starting in the first cycle after reset release. imem_addr_o=PC always.
- FSM states: FETCH, WAIT, FULL, DROP.
  - FETCH: on gnt → WAIT.
  - WAIT: on rvalid → capture rdata and PC into the buffer, if_valid_o=1 next cycle, PC<=PC+4, state → FULL.
  - FULL: if_valid_o=1. When !stall_i, the handoff completes that edge: if_valid_o→0, state → FETCH. While stall_i=1, outputs hold.
  - DROP: discard the next rvalid without updating the buffer, then → FETCH.
- Redirect: redirect = res_valid_i && (jump_i || (branch_i && (branch_eq_i ? zero_i : !zero_i))).
- Redirect target:
  - branch: res_pc4_i + {{14{imm[15]}}, imm, 2'b00}
  - J/JAL: {res_pc4_i[31:28], jidx, 2'b00}
  - JR: {rs[31:2], 2'b00}, with misalign_o=1 the next cycle if rs[1:0] != 0.
  - jump_i has priority over branch_i.
- On redirect (takes priority over stall_i and over any same-cycle gnt/rvalid), PC<=target and if_valid_o<=0. Next state by current state:
  - FETCH without gnt: FETCH at the new PC.
  - FETCH with gnt: DROP.
  - WAIT without rvalid: DROP.
  - WAIT with rvalid: FETCH; the response is discarded.
  - FULL: FETCH.
  - DROP: stays DROP, but goes to FETCH if rvalid arrives that cycle.
- The captured PC advances +4 with 32-bit wrap-around (32'hFFFF_FFFC → 0).
- Latency: with gnt in the request cycle and rvalid one cycle later, the instruction is visible 2 cycles after req rises. Peak throughput is 1 instruction per 3 cycles.
- Protocol errors: rvalid in FETCH/FULL is ignored. A misaligned RESET_PC is used unchanged.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants
  - jump_ctrl encodings JC_J=0, JC_JAL=1, JC_JR=2
  - fetch state enum {FETCH, WAIT, FULL, DROP}
  - constant INSTR_W=32
- One combinational sub-module next_pc_calc computes the redirect flag, the target, and the misalign condition.

Test Plan:
- Reset, RESET_PC=32'h100, gnt immediate, rvalid +1 with 32'h2008_0005 → req at 0x100; if_valid_o=1 with if_pc_o=0x100 and if_pc4_o=0x104 two cycles after req; next req at 0x104.
- Hold stall_i=1 for 5 cycles in FULL → outputs stable and imem_req_o=0 throughout; release → req at next PC.
- BEQ resolve: branch_i=1, branch_eq_i=1, zero_i=1, res_pc4_i=0x200, imm=16'hFFFE → next req address 0x1F8. Same with zero_i=0 → no redirect.
- Redirect while in WAIT, J jidx=26'h40, res_pc4_i=0x1000_0010 → stale rvalid dropped (if_valid_o stays 0), next req 0x1000_0100.
- JR with rs=0x0000_0303 → target 0x300 and misalign_o pulses one cycle. Redirect concurrent with stall_i in FULL → buffer flushed, fetch at target.
- Assert rst_n=0 mid-WAIT → all outputs 0 immediately, asynchronously; after release, req at RESET_PC.
